// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the score display scanner.
// Holds digit count, BCD limit, anode patterns and slot select type.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    localparam logic [3:0] AN_SEL0 = 4'b1110;
    localparam logic [3:0] AN_SEL1 = 4'b1101;
    localparam logic [3:0] AN_SEL2 = 4'b1011;
    localparam logic [3:0] AN_SEL3 = 4'b0111;

    typedef logic [1:0] digit_sel_t;

    function automatic logic [3:0] an_for(input digit_sel_t s);
        logic [3:0] r;
        r = AN_ALL_OFF;
        case (s)
            2'd0: r = AN_SEL0;
            2'd1: r = AN_SEL1;
            2'd2: r = AN_SEL2;
            2'd3: r = AN_SEL3;
            default: r = AN_ALL_OFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade adder: sum = value + addend + carry_in, mod 10.
// Ports: value, addend (BCD nibbles), carry_in -> sum, carry_out.
module bcd_decade
    import sevenseg_pkg::*;
(
    input  logic [3:0] value,
    input  logic [3:0] addend,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [4:0] raw;
    logic [4:0] adj;

    assign raw = {1'b0, value} + {1'b0, addend} + {4'b0, carry_in};
    assign adj = raw - 5'd10;
    assign carry_out = (raw > {1'b0, BCD_MAX});
    assign sum = carry_out ? adj[3:0] : raw[3:0];

endmodule

// File: rtl/score_display_scanner.sv
// 4-digit BCD score counter with time-multiplexed digit bus and
// active-low anode enables. Ports: clk, reset (sync, high), inc, clr,
// freeze -> digit[3:0], an[3:0], score_bcd[15:0], sat.
// Optional macro SCORE_LZ_BLANK_EN blanks leading zero digits.
module score_display_scanner
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SCORE_STEP  = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    input  logic        freeze,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic [15:0] score_bcd,
    output logic        sat
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);
    localparam logic [3:0] STEP = 4'(SCORE_STEP);

    logic [NUM_DIGITS:0] carry;
    logic [15:0]         sum;
    logic [CW-1:0]       scan_cnt;
    digit_sel_t          slot;
    logic                blank;
    logic [3:0]          disp_an;
    logic [3:0]          disp_digit;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        bcd_decade u_dec (
            .value     (score_bcd[4*i +: 4]),
            .addend    ((i == 0) ? STEP : 4'h0),
            .carry_in  (carry[i]),
            .sum       (sum[4*i +: 4]),
            .carry_out (carry[i+1])
        );
    end

    // A carry out of the thousands decade means the sum passed 9999.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_bcd <= 16'h0000;
            sat       <= 1'b0;
        end else if (clr) begin
            score_bcd <= 16'h0000;
            sat       <= 1'b0;
        end else if (inc && !freeze) begin
            if (carry[NUM_DIGITS]) begin
                score_bcd <= 16'h9999;
                sat       <= 1'b1;
            end else begin
                score_bcd <= sum;
            end
        end
    end

    always_comb begin
        blank = 1'b0;
`ifdef SCORE_LZ_BLANK_EN
        case (slot)
            2'd1: blank = (score_bcd[15:4] == 12'h000);
            2'd2: blank = (score_bcd[15:8] == 8'h00);
            2'd3: blank = (score_bcd[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
        disp_an    = blank ? AN_ALL_OFF : an_for(slot);
        disp_digit = blank ? 4'h0 : score_bcd[{slot, 2'b00} +: 4];
    end

    // digit and an load together from the pre-edge slot and score.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            slot     <= 2'd0;
            digit    <= 4'h0;
            an       <= AN_ALL_OFF;
        end else begin
            if (scan_cnt == TC) begin
                scan_cnt <= '0;
                slot     <= slot + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            digit <= disp_digit;
            an    <= disp_an;
        end
    end

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed bench for score_display_scanner with REFRESH_DIV = 4.
// Second instance uses SCORE_STEP = 5.
module tb_score_display_scanner;

`ifdef SCORE_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, inc, clr, freeze;
    logic [3:0]  digit, an;
    logic [15:0] score_bcd;
    logic        sat;

    logic        reset5, inc5, clr5, freeze5;
    logic [3:0]  digit5, an5;
    logic [15:0] score5;
    logic        sat5;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    score_display_scanner #(.REFRESH_DIV(4), .SCORE_STEP(1)) dut (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr), .freeze(freeze),
        .digit(digit), .an(an), .score_bcd(score_bcd), .sat(sat)
    );

    score_display_scanner #(.REFRESH_DIV(4), .SCORE_STEP(5)) dut5 (
        .clk(clk), .reset(reset5), .inc(inc5), .clr(clr5), .freeze(freeze5),
        .digit(digit5), .an(an5), .score_bcd(score5), .sat(sat5)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench on the first cycle that slot 1 is displayed.
    task automatic to_slot1(input bit five, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 24 && !ok; i++) begin
            @(negedge clk);
            if ((five ? an5 : an) === 4'b1110) ok = 1'b1;
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 8 && !ok; i++) begin
                @(negedge clk);
                if ((five ? an5 : an) !== 4'b1110) ok = 1'b1;
            end
        end
        chk(tag, {15'h0, ok}, 16'h0001);
    endtask

    task automatic pulses(input int n);
        inc = 1'b1;
        repeat (n) @(negedge clk);
        inc = 1'b0;
    endtask

    logic [3:0] exp_an [4];

    initial begin
        exp_an[0] = 4'b1110;
        exp_an[1] = 4'b1101;
        exp_an[2] = 4'b1011;
        exp_an[3] = 4'b0111;

        reset = 1'b1; inc = 1'b0; clr = 1'b0; freeze = 1'b0;
        reset5 = 1'b1; inc5 = 1'b0; clr5 = 1'b0; freeze5 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_digit", {12'h0, digit}, 16'h0000);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_sat", {15'h0, sat}, 16'h0000);

        reset = 1'b0;
        reset5 = 1'b0;

        // Score 0: only slot 0 is never blanked, so check an there only
        // when blanking is on.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!LZ || (k / 4) % 4 == 0)
                chk($sformatf("scan_k%0d", k), {12'h0, an},
                    {12'h0, exp_an[(k / 4) % 4]});
            else
                chk($sformatf("scan_blank_k%0d", k), {12'h0, an}, 16'h000F);
        end

        pulses(42);
        chk("score_42", score_bcd, 16'h0042);
        to_slot1(1'b0, "sync_42");
        chk("s1_an_42", {12'h0, an}, 16'h000D);
        chk("s1_dig_42", {12'h0, digit}, 16'h0004);
        repeat (4) @(negedge clk);
        chk("s2_an_42", {12'h0, an}, LZ ? 16'h000F : 16'h000B);
        chk("s2_dig_42", {12'h0, digit}, 16'h0000);
        repeat (4) @(negedge clk);
        chk("s3_an_42", {12'h0, an}, LZ ? 16'h000F : 16'h0007);
        chk("s3_dig_42", {12'h0, digit}, 16'h0000);
        repeat (4) @(negedge clk);
        chk("s0_an_42", {12'h0, an}, 16'h000E);
        chk("s0_dig_42", {12'h0, digit}, 16'h0002);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_0", score_bcd, 16'h0000);

        pulses(999);
        chk("score_999", score_bcd, 16'h0999);
        pulses(1);
        chk("ripple_1000", score_bcd, 16'h1000);
        chk("ripple_sat", {15'h0, sat}, 16'h0000);

        pulses(8999);
        chk("score_9999", score_bcd, 16'h9999);
        chk("sat_9999", {15'h0, sat}, 16'h0000);
        pulses(1);
        chk("sat_hold", score_bcd, 16'h9999);
        chk("sat_set", {15'h0, sat}, 16'h0001);
        @(negedge clk);
        chk("sat_sticky", {15'h0, sat}, 16'h0001);

        clr = 1'b1; inc = 1'b1;
        @(negedge clk);
        clr = 1'b0; inc = 1'b0;
        chk("clrinc_score", score_bcd, 16'h0000);
        chk("clrinc_sat", {15'h0, sat}, 16'h0000);

        freeze = 1'b1;
        pulses(5);
        chk("frz_score", score_bcd, 16'h0000);
        to_slot1(1'b0, "frz_scan");
        chk("frz_s1_an", {12'h0, an}, LZ ? 16'h000F : 16'h000D);
        freeze = 1'b0;
        pulses(1);
        chk("unfrz_score", score_bcd, 16'h0001);

        // Step-5 instance: 0 -> 5 -> 10 -> 15.
        inc5 = 1'b1;
        @(negedge clk);
        inc5 = 1'b0;
        chk("s5_0005", score5, 16'h0005);
        inc5 = 1'b1;
        @(negedge clk);
        inc5 = 1'b0;
        chk("s5_0010", score5, 16'h0010);
        inc5 = 1'b1;
        @(negedge clk);
        inc5 = 1'b0;
        chk("s5_0015", score5, 16'h0015);

        to_slot1(1'b1, "s5_sync");
        chk("s5_s1_dig", {12'h0, digit5}, 16'h0001);
        repeat (5) @(negedge clk);
        chk("s5_s2_an", {12'h0, an5}, LZ ? 16'h000F : 16'h000B);
        reset5 = 1'b1;
        @(negedge clk);
        chk("s5_rst_an", {12'h0, an5}, 16'h000F);
        chk("s5_rst_dig", {12'h0, digit5}, 16'h0000);
        chk("s5_rst_score", score5, 16'h0000);
        chk("s5_rst_sat", {15'h0, sat5}, 16'h0000);
        reset5 = 1'b0;
        @(negedge clk);
        chk("s5_post_an", {12'h0, an5}, 16'h000E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
